// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/baud_gen.sv
// Rate generator: one-clk tick every CLK_FREQ/BAUD clocks (integer division).
module baud_gen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = (CLK_FREQ / BAUD) > 1 ? (CLK_FREQ / BAUD) : 2;
  localparam int W   = $clog2(DIV);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and framing-error detection.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err
);

  import uart_pkg::*;

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_t state, state_n;
  logic        rx_meta, rx_s, rx_prev;
  logic        os_tick;
  logic [3:0]  tick_cnt, tick_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_n;
  logic        valid_n, frame_err_n;

  baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD * OVERSAMPLE)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (os_tick)
  );

  // Synchronizer and edge-detect flops reset to the idle-line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      data_out  <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
    end
  end

  // Start is armed only by a 1->0 transition, so a held-low line cannot retrigger.
  always_comb begin
    state_n     = state;
    tick_cnt_n  = tick_cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    data_n      = data_out;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end
      START: begin
        if (os_tick) begin
          if (tick_cnt == MID_TICK) begin
            tick_cnt_n = '0;
            bit_idx_n  = '0;
            state_n    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_n       = '0;
            shift_n[bit_idx] = rx_s;
            if (bit_idx == LAST_BIT) state_n = STOP;
            else bit_idx_n = bit_idx + 1'b1;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (os_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_n = '0;
            state_n    = IDLE;
            if (rx_s) begin
              data_n  = shift;
              valid_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frame-level expectations queued by the driver, checked by a monitor.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 6250;
  localparam int BIT_CLKS = (CLK_FREQ / (BAUD * 16)) * 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid, busy, frame_err;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } event_t;

  event_t     exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         errors = 0;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveBit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // Queue what a correct receiver must report for this frame, then put it on the line.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_ok);
    event_t e;
    e.is_err = !stop_ok;
    e.data   = stop_ok ? b : last_good;
    if (stop_ok) last_good = b;
    exp_q.push_back(e);
    driveBit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) driveBit(b[i], BIT_CLKS);
    driveBit(stop_ok, BIT_CLKS);
  endtask

  always @(negedge clk) begin
    if (!rst && (valid || frame_err)) begin
      event_t e;
      checkOutput("valid_ferr_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", {30'd0, valid, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_kind_ferr", {31'd0, frame_err}, {31'd0, e.is_err});
        checkOutput("data_out", {24'd0, data_out}, {24'd0, e.data});
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       ok;
    int         waited;

    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("reset_data_out", {24'd0, data_out}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    driveBit(1'b1, 2 * BIT_CLKS);

    applyStimulus(8'hA5, 1'b1);
    driveBit(1'b1, BIT_CLKS);

    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    driveBit(1'b1, BIT_CLKS);

    // Short low pulse: must be rejected at the mid-start check.
    driveBit(1'b0, 30);
    checkOutput("glitch_busy_rises", {31'd0, busy}, 32'd1);
    driveBit(1'b1, BIT_CLKS + BIT_CLKS / 2 - 30 + 10);
    checkOutput("glitch_busy_cleared", {31'd0, busy}, 32'd0);
    driveBit(1'b1, BIT_CLKS);

    applyStimulus(8'h55, 1'b0);
    driveBit(1'b1, BIT_CLKS);

    // Break: three frame times low gives exactly one framing error and no restart.
    begin
      event_t e;
      e.is_err = 1'b1;
      e.data   = last_good;
      exp_q.push_back(e);
    end
    driveBit(1'b0, 30 * BIT_CLKS);
    checkOutput("break_no_restart_busy", {31'd0, busy}, 32'd0);
    driveBit(1'b1, 2 * BIT_CLKS);

    // Reset in the middle of data bit 4 of 8'hC3; the partial byte must vanish.
    b = 8'hC3;
    driveBit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) driveBit(b[i], BIT_CLKS);
    driveBit(b[4], BIT_CLKS / 2);
    rst = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    checkOutput("midframe_rst_busy", {31'd0, busy}, 32'd0);
    driveBit(b[4], BIT_CLKS / 2 - 1);
    for (int i = 5; i < 8; i++) driveBit(b[i], BIT_CLKS);
    driveBit(1'b1, BIT_CLKS);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_data_out", {24'd0, data_out}, 32'd0);
    driveBit(1'b1, BIT_CLKS);
    applyStimulus(8'h81, 1'b1);
    driveBit(1'b1, BIT_CLKS);

    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      applyStimulus(b, ok);
      driveBit(1'b1, BIT_CLKS * (ok ? $urandom_range(0, 2) : $urandom_range(1, 2)));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 4 * BIT_CLKS) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    driveBit(1'b1, BIT_CLKS);
    checkOutput("final_idle_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
